// File: rtl/keccak_padder.sv
// Purpose : collects 64-bit message words into RATE_WORDS-word blocks and applies
//           pad10*1 to the final block before it goes to the permutation.
// Latency : full block valid on the edge that accepts its last word; a final block
//           needs one extra cycle per unwritten slot (RATE_WORDS-1-k cycles).
// Backpressure: buffer_full is high while padding, holding a block or finished;
//           a word offered while buffer_full=1 is not taken and stays with the producer.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset clearing all state
//   in, in_ready        message word (first byte in in[63:56]) and its valid strobe
//   is_last, byte_num   final-word marker and count of valid bytes in the final word
//   buffer_full         padder cannot take a word this cycle
//   out_block           assembled block, word 0 in the most significant 64 bits
//   out_valid, out_last block present / block is the final padded one
//   out_ack             permutation has consumed out_block
//
// Build option: define PADDER_SHA3_EN to use the FIPS-202 SHA-3 domain pad byte
// (0x06) instead of the original Keccak pad byte (0x01).

module keccak_padder #(
    parameter int RATE_WORDS = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [63:0]             in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [2:0]              byte_num,
    output logic                    buffer_full,
    output logic [64*RATE_WORDS-1:0] out_block,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ack
);

    localparam int              KW     = $clog2(RATE_WORDS);
    localparam logic [KW-1:0]   K_LAST = KW'(RATE_WORDS - 1);

`ifdef PADDER_SHA3_EN
    // SHA-3 appends the domain bits "01" ahead of the first pad bit.
    localparam logic [7:0]      PAD_BYTE = 8'h06;
`else
    localparam logic [7:0]      PAD_BYTE = 8'h01;
`endif

    // Terminating bit of pad10*1, placed in the last byte of the block.
    localparam logic [7:0]      END_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        FULL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic               last_q, last_d;
    logic [63:0]        slot_q [RATE_WORDS];
    logic [63:0]        slot_d [RATE_WORDS];

    // ------------------------------------------------------------------
    // Final-word shaping: keep the valid leading bytes, drop producer
    // filler, and drop the pad byte in right after the message.
    // ------------------------------------------------------------------
    logic [63:0] keep_mask;
    logic [63:0] pad_word;
    logic [63:0] shaped_word;
    logic [63:0] last_word;

    always_comb begin
        // byte_num=0 yields an all-zero mask, so only the pad byte survives.
        keep_mask   = ~(64'hFFFF_FFFF_FFFF_FFFF >> {byte_num, 3'b000});
        pad_word    = {56'h0, PAD_BYTE} << {3'd7 - byte_num, 3'b000};
        shaped_word = (in & keep_mask) | pad_word;
        // When the final word lands in the last slot the closing 0x80 shares
        // the block with the message, so it is merged into the low byte here.
        if (k_q == K_LAST) begin
            last_word = shaped_word | {56'h0, END_BYTE};
        end else begin
            last_word = shaped_word;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        last_d  = last_q;
        slot_d  = slot_q;

        case (state_q)
            ACCEPT: begin
                if (in_ready) begin
                    if (is_last) begin
                        slot_d[k_q] = last_word;
                        if (k_q == K_LAST) begin
                            k_d     = '0;
                            last_d  = 1'b1;
                            state_d = FULL;
                        end else begin
                            k_d     = k_q + 1'b1;
                            state_d = PAD;
                        end
                    end else begin
                        slot_d[k_q] = in;
                        if (k_q == K_LAST) begin
                            k_d     = '0;
                            state_d = FULL;
                        end else begin
                            k_d     = k_q + 1'b1;
                        end
                    end
                end
            end

            PAD: begin
                // Walk the remaining slots one per cycle; the last one closes
                // the padding with the end bit.
                if (k_q == K_LAST) begin
                    slot_d[k_q] = {56'h0, END_BYTE};
                    k_d         = '0;
                    last_d      = 1'b1;
                    state_d     = FULL;
                end else begin
                    slot_d[k_q] = 64'h0;
                    k_d         = k_q + 1'b1;
                end
            end

            FULL: begin
                if (out_ack) begin
                    if (last_q) begin
                        // Block contents and out_last are left in place as the
                        // end-of-message marker for the output stage.
                        state_d = DONE;
                    end else begin
                        for (int i = 0; i < RATE_WORDS; i++) begin
                            slot_d[i] = 64'h0;
                        end
                        state_d = ACCEPT;
                    end
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCEPT;
            k_q     <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < RATE_WORDS; i++) begin
                slot_q[i] <= 64'h0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            last_q  <= last_d;
            for (int i = 0; i < RATE_WORDS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign buffer_full = (state_q != ACCEPT);
    assign out_valid   = (state_q == FULL);
    assign out_last    = last_q;

    always_comb begin
        out_block = '0;
        for (int i = 0; i < RATE_WORDS; i++) begin
            out_block[64*(RATE_WORDS-1-i) +: 64] = slot_q[i];
        end
    end

endmodule
